util_trafic_test_ctrl: RTL

//  Sequencer for one AXI-Stream traffic test: generator -> DUT path -> traffic receiver.
//  - Arms and resets the receiver, enables generator and receiver, monitors the receiver-side handshake.
//  - Counts beats, packets, errors and cycles; stops on beat target, timeout or abort.
//  - Reports pass/fail. Sits beside util_trafic_receiver and its generator; driven by a register block or testbench.

---
 rtl/util_trafic_test_ctrl_if.sv | 22 ++
 rtl/util_trafic_test_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/util_trafic_test_ctrl_if.sv
// Control and monitor tap between the test controller and the generator/receiver pair.
// Master side drives the enables and the receiver reset and observes the receiver's AXI-Stream handshake.
// Slave side (generator/receiver/bench) drives the handshake taps and the receiver error.
interface util_trafic_test_ctrl_if;
   logic gen_en;
   logic rcv_en;
   logic rcv_rst;
   logic mon_tvalid;
   logic mon_tready;
   logic mon_tlast;
   logic rcv_error;

   modport master (
      output gen_en, rcv_en, rcv_rst,
      input  mon_tvalid, mon_tready, mon_tlast, rcv_error
   );

   modport slave (
      input  gen_en, rcv_en, rcv_rst,
      output mon_tvalid, mon_tready, mon_tlast, rcv_error
   );
endinterface

// File: rtl/util_trafic_test_ctrl.sv
// Sequencer for one AXI-Stream traffic test: arm, run, drain, report pass/fail with beat/pkt/err/cycle counts.
// Latency: ARM 1 cycle, enables rise the cycle after ARM, DRAIN_CYCLES of drain, 1-cycle DONE pulse.
// Backpressure: passive monitor only; beats counted on mon_tvalid&mon_tready. Option: UTIL_TRAFIC_CTRL_STOP_ON_ERR_EN.
module util_trafic_test_ctrl #(
   parameter int DRAIN_CYCLES = 16,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [CNT_WIDTH-1:0] beat_target,
   input  logic [CNT_WIDTH-1:0] timeout,
   util_trafic_test_ctrl_if.master tap,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 timed_out,
   output logic                 aborted,
   output logic [CNT_WIDTH-1:0] beat_cnt,
   output logic [CNT_WIDTH-1:0] pkt_cnt,
   output logic [CNT_WIDTH-1:0] err_cnt,
   output logic [CNT_WIDTH-1:0] cycle_cnt
);

   localparam int DW = $clog2(DRAIN_CYCLES + 1);
   localparam logic [DW-1:0]        DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
   localparam logic [DW-1:0]        DRAIN_ONE  = DW'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] target_q, timeout_q;
   logic [DW-1:0]        drain_q;
   logic                 first_pend, acc_d, acc_d_seed;
   logic                 gen_en_c, rcv_en_c, rcv_rst_c;
   logic                 acc, err_hit, hit_err, hit_timeout, hit_target, drain_last;
   logic [CNT_WIDTH-1:0] beat_nxt, pkt_nxt, err_nxt, cycle_nxt;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   // A beat only counts while the receiver is enabled; the error compare for the seed beat is skipped
   // because it checks against the receiver's reset value rather than a real predecessor.
   always_comb begin
      acc         = tap.mon_tvalid & tap.mon_tready & ((state == S_RUN) | (state == S_DRAIN));
      err_hit     = acc_d & ~acc_d_seed & tap.rcv_error;
      beat_nxt    = acc ? sat_inc(beat_cnt) : beat_cnt;
      pkt_nxt     = (acc & tap.mon_tlast) ? sat_inc(pkt_cnt) : pkt_cnt;
      err_nxt     = err_hit ? sat_inc(err_cnt) : err_cnt;
      cycle_nxt   = sat_inc(cycle_cnt);
      hit_target  = (target_q != '0) && (beat_nxt >= target_q);
      hit_timeout = (timeout_q != '0) && (cycle_nxt == timeout_q);
      drain_last  = (drain_q == DRAIN_LAST);
`ifdef UTIL_TRAFIC_CTRL_STOP_ON_ERR_EN
      hit_err     = err_hit;
`else
      hit_err     = 1'b0;
`endif
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state and control outputs.
   always_comb begin
      state_nxt = state;
      gen_en_c  = 1'b0;
      rcv_en_c  = 1'b0;
      rcv_rst_c = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: if (start & ~abort) state_nxt = S_ARM;
         S_ARM: begin
            rcv_rst_c = 1'b1;
            busy      = 1'b1;
            state_nxt = S_RUN;
         end
         S_RUN: begin
            gen_en_c = 1'b1;
            rcv_en_c = 1'b1;
            busy     = 1'b1;
            if (abort | hit_err | hit_timeout | hit_target) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            rcv_en_c = 1'b1;
            busy     = 1'b1;
            if (drain_last) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign tap.gen_en  = gen_en_c;
   assign tap.rcv_en  = rcv_en_c;
   assign tap.rcv_rst = rcv_rst_c;

   // Drain timer runs only while draining and restarts from zero on every entry.
   always_ff @(posedge clk) begin
      if (rst || state != S_DRAIN) drain_q <= '0;
      else                         drain_q <= drain_q + DRAIN_ONE;
   end

   // Counters, end-of-test flags and the verdict; cleared in ARM and otherwise held between tests.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt   <= '0;
         pkt_cnt    <= '0;
         err_cnt    <= '0;
         cycle_cnt  <= '0;
         target_q   <= '0;
         timeout_q  <= '0;
         timed_out  <= 1'b0;
         aborted    <= 1'b0;
         pass       <= 1'b0;
         first_pend <= 1'b0;
         acc_d      <= 1'b0;
         acc_d_seed <= 1'b0;
      end else if (state == S_ARM) begin
         beat_cnt   <= '0;
         pkt_cnt    <= '0;
         err_cnt    <= '0;
         cycle_cnt  <= '0;
         target_q   <= beat_target;
         timeout_q  <= timeout;
         timed_out  <= 1'b0;
         aborted    <= 1'b0;
         pass       <= 1'b0;
         first_pend <= 1'b1;
         acc_d      <= 1'b0;
         acc_d_seed <= 1'b0;
      end else begin
         beat_cnt   <= beat_nxt;
         pkt_cnt    <= pkt_nxt;
         err_cnt    <= err_nxt;
         acc_d      <= acc;
         acc_d_seed <= acc & first_pend;
         if (acc) first_pend <= 1'b0;
         if (state == S_RUN) begin
            cycle_cnt <= cycle_nxt;
            if (abort | hit_err) aborted   <= 1'b1;
            else if (hit_timeout) timed_out <= 1'b1;
         end
         if (state == S_DRAIN && drain_last)
            pass <= ~aborted & ~timed_out & (err_nxt == '0) &
                    ((target_q == '0) | (beat_nxt >= target_q));
      end
   end

endmodule
